lut_config_loader: RTL

Serial configuration loader that sits directly upstream of the 3-input LUT array. It accepts a framed serial bitstream over a valid/ready handshake, checks it, and drives the truth-table constant inputs of NUM_LUTS LUT instances. A new configuration is committed atomically, and only after the frame passes the parity check. This keeps the LUT fabric from ever seeing a partial or corrupted truth table.

---
 rtl/lut_config_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lut_config_loader.sv
// Serial frame loader for the 3-input LUT array: hunts SYNC_WORD, shifts in NUM_LUTS*8 data bits plus even parity.
// Latency: parity bit accepted at edge T commits cfg_out and raises done/err at edge T+1.
// Backpressure: cfg_ready is high only in SYNC and LOAD; bits offered while it is low are ignored.
module lut_config_loader #(
  parameter int          NUM_LUTS  = 4,
  parameter int          LUT_BITS  = 8,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cfg_valid,
  input  logic                         cfg_bit,
  output logic                         cfg_ready,
  output logic [NUM_LUTS*LUT_BITS-1:0] cfg_out,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int N  = NUM_LUTS * LUT_BITS;
  localparam int CW = $clog2(N + 2);
  // Counter value at which the incoming bit is the parity bit rather than data.
  localparam logic [CW-1:0] PARITY_POS = CW'(N);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [7:0]    window;
  logic [7:0]    window_shift;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shadow;
  logic          parity;
  logic          xfer;

  assign xfer         = cfg_valid && cfg_ready;
  assign window_shift = {window[6:0], cfg_bit};

  // Next-state decode; parity holds the XOR of every data bit and the parity bit once in CHECK.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_SYNC;
      ST_SYNC:  if (xfer && (window_shift == SYNC_WORD)) state_nxt = ST_LOAD;
      ST_LOAD:  if (xfer && (cnt == PARITY_POS)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = parity ? ST_ERROR : ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register with cfg_ready/busy registered as decodes of the incoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == ST_SYNC) || (state_nxt == ST_LOAD);
      busy      <= (state_nxt == ST_SYNC) || (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
    end
  end

  // Header window, bit counter, shadow shift register and running parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      cnt    <= '0;
      shadow <= '0;
      parity <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // A fresh hunt must never match on bits left over from an earlier frame.
          if (start) window <= '0;
        end
        ST_SYNC: begin
          if (xfer) begin
            window <= window_shift;
            if (window_shift == SYNC_WORD) begin
              cnt    <= '0;
              parity <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            parity <= parity ^ cfg_bit;
            cnt    <= cnt + 1'b1;
            // Shifting in at the top leaves the k-th data bit in shadow[k] after N bits.
            if (cnt != PARITY_POS) shadow <= {cfg_bit, shadow[N-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Atomic commit of the truth tables and the done/err status levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_out <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            done <= 1'b0;
            err  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!parity) begin
            cfg_out <= shadow;
            done    <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
